// File: rtl/ecg_sample_uart_tx.sv
// ecg_sample_uart_tx
// Buffers 12-bit ADC samples in a small FIFO and serialises each one as two
// 8N1 UART bytes: byte0 = {1,0,D[11:6]} (bit 7 is the frame sync), then
// byte1 = {0,0,D[5:0]}. Each byte is sent LSB first.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data[11:0] : sample word, stable while dv is high
//   dv         : data-valid level; each rising edge is one new sample
//   tx         : UART line, idle high (registered)
//   busy       : FIFO non-empty or frame in progress (registered)
//   overflow   : sticky, set when a sample is dropped (registered)
//   fifo_level : number of buffered samples (registered)
module ecg_sample_uart_tx #(
   parameter real         FCLK       = 100e6,
   parameter real         BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [11:0]                 data,
   input  logic                        dv,
   output logic                        tx,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   // Bit period, rounded to the nearest whole clock
   localparam int unsigned CLKS_PER_BIT = $rtoi(FCLK / BAUD + 0.5);
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W        = PTR_W + 1;
   localparam int unsigned SAMPLE_W     = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic                byte_idx_q, byte_idx_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [LVL_W-1:0]    level_d;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic                dv_q;
   logic                armed;
   logic                tx_d;
   logic                busy_d;

   logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic       sample_ev_c;
   logic       pop_c;
   logic       full_c;
   logic       wr_c;
   logic       drop_c;
   logic       bit_end_c;
   logic [7:0] cur_byte_c;

   // A rising dv only counts once dv has been seen low since reset, so a dv
   // that is already high when reset releases is not mistaken for a sample.
   assign sample_ev_c = dv & ~dv_q & armed;

   // The transmitter takes a sample whenever it is idle and one is waiting.
   assign pop_c  = (state_q == IDLE) && (fifo_level != '0);
   assign full_c = (fifo_level == LVL_W'(FIFO_DEPTH));

   // A full FIFO still accepts the sample if a slot frees up this cycle.
   assign wr_c   = sample_ev_c && (!full_c || pop_c);
   assign drop_c = sample_ev_c && !wr_c;

   assign bit_end_c = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // Byte on the wire for the latched sample
   assign cur_byte_c = byte_idx_q ? {2'b00, sample_q[5:0]}
                                  : {2'b10, sample_q[11:6]};

   // Level bookkeeping: write and pop in the same cycle cancel out
   always_comb begin
      level_d = fifo_level;
      unique case ({wr_c, pop_c})
         2'b10:   level_d = fifo_level + LVL_W'(1);
         2'b01:   level_d = fifo_level - LVL_W'(1);
         default: level_d = fifo_level;
      endcase
   end

   // ------------------------------------------------------------------
   // Transmit FSM: next state and next register values
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      sample_d   = sample_q;
      tx_d       = 1'b1;
      // Bit-period counter only runs while a frame is active
      if (state_q == IDLE) begin
         bit_cnt_d = '0;
      end else if (bit_end_c) begin
         bit_cnt_d = '0;
      end else begin
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop_c) begin
               sample_d   = mem[rd_ptr];
               byte_idx_d = 1'b0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end

         START: begin
            tx_d = 1'b0;
            if (bit_end_c) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte_c[0];
            end
         end

         DATA: begin
            tx_d = cur_byte_c[bit_idx_q];
            if (bit_end_c) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_byte_c[bit_idx_q + 3'd1];
               end
            end
         end

         STOP: begin
            tx_d = 1'b1;
            if (bit_end_c) begin
               if (!byte_idx_q) begin
                  // Second byte of the same sample follows immediately
                  byte_idx_d = 1'b1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE) || (level_d != '0);
   end

   // ------------------------------------------------------------------
   // State, control and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 1'b0;
         sample_q   <= '0;
         fifo_level <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         dv_q       <= 1'b0;
         armed      <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         sample_q   <= sample_d;
         fifo_level <= level_d;
         dv_q       <= dv;
         tx         <= tx_d;
         busy       <= busy_d;
         if (!dv) begin
            armed <= 1'b1;
         end
         // Pointers wrap naturally: depth is a power of two
         if (wr_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (drop_c) begin
            overflow <= 1'b1;
         end
      end
   end

   // Sample storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem[wr_ptr] <= data;
      end
   end

endmodule

// File: tb/tb_ecg_sample_uart_tx.sv
// Testbench for ecg_sample_uart_tx at FCLK=1 MHz, BAUD=100 kbaud (10 clocks
// per bit), FIFO depth 4. A UART receiver decodes the tx line into bytes;
// expected bytes come from the sample encoding written as plain arithmetic.
module tb_ecg_sample_uart_tx;

   localparam int CPB   = 10;
   localparam int DEPTH = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [11:0] data = '0;
   logic       dv    = 1'b0;
   logic       tx;
   logic       busy;
   logic       overflow;
   logic [2:0] fifo_level;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   int         mon_err = 0;
   bit         mon_act = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_sh  = '0;
   logic       tx_prev = 1'b1;

   ecg_sample_uart_tx #(
      .FCLK      (1e6),
      .BAUD      (100000.0),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .dv        (dv),
      .tx        (tx),
      .busy      (busy),
      .overflow  (overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // UART receiver: samples mid-bit on falling clock edges
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_act = 1'b0;
         tx_prev = 1'b1;
      end else begin
         if (!mon_act) begin
            if (tx_prev === 1'b1 && tx === 1'b0) begin
               mon_act = 1'b1;
               mon_cnt = 0;
            end
         end else begin
            mon_cnt++;
            if (mon_cnt == CPB / 2 - 1) begin
               if (tx !== 1'b0) begin
                  mon_err++;
                  mon_act = 1'b0;
               end
            end else if (mon_cnt == CPB / 2 - 1 + 9 * CPB) begin
               if (tx !== 1'b1) mon_err++;
               else rx_q.push_back(mon_sh);
               mon_act = 1'b0;
            end else if ((mon_cnt - (CPB / 2 - 1)) % CPB == 0) begin
               mon_sh[(mon_cnt - (CPB / 2 - 1)) / CPB - 1] = tx;
            end
         end
         tx_prev = tx;
      end
   end

   // Expected byte pair for one sample
   function automatic void push_sample(input logic [11:0] d);
      exp_q.push_back(8'(128 + int'(d) / 64));
      exp_q.push_back(8'(int'(d) % 64));
   endfunction

   task automatic pulse(input logic [11:0] d);
      data = d;
      dv   = 1'b1;
      @(negedge clk);
      dv   = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < 5000) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      dv    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset;
      #3 rst_n = 1'b0;
      #1;
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: tx=%b busy=%b expected 1/0", tx, busy); end
   endtask

   task automatic test_single;
      int lat;
      int len;
      bit ok;
      data = 12'hABC;
      dv   = 1'b1;
      lat  = 0;
      push_sample(12'hABC);
      do begin
         @(negedge clk);
         lat++;
         dv = 1'b0;
      end while (tx !== 1'b0 && lat < 20);
      n_vec++; if (lat > 4 || tx !== 1'b0) begin n_err++; $display("FAIL single_latency: got %0d cycles expected <=4", lat); end
      len = 0;
      while (busy === 1'b1 && len < 400) begin
         len++;
         @(negedge clk);
      end
      n_vec++; if (len != 20 * CPB) begin n_err++; $display("FAIL single_length: got %0d expected %0d", len, 20 * CPB); end
      drain(ok);
      n_vec++; if (!ok || busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b expected 0", busy); end
      n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_boundary;
      bit ok;
      pulse(12'h000); push_sample(12'h000); drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL boundary_drain0: busy stuck, got %b expected 0", busy); end
      pulse(12'hFFF); push_sample(12'hFFF); drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL boundary_drain1: busy stuck, got %b expected 0", busy); end
      n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL boundary_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL boundary_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_level_dv;
      bit ok;
      logic [11:0] d;
      d    = 12'($urandom);
      data = d;
      dv   = 1'b1;
      push_sample(d);
      repeat (1000) @(negedge clk);
      dv = 1'b0;
      drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL level_drain: busy stuck, got %b expected 0", busy); end
      n_vec++; if (rx_q.size() != 2) begin n_err++; $display("FAIL level_count: got %0d expected 2", rx_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL level_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_burst;
      bit ok;
      do_reset;
      for (int i = 1; i <= 6; i++) begin
         pulse(12'(i));
         if (i <= 5) push_sample(12'(i));
      end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL burst_overflow: got %b expected 1", overflow); end
      n_vec++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL burst_level: got %0d expected %0d", fifo_level, DEPTH); end
      drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL burst_drain: busy stuck, got %b expected 0", busy); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL burst_sticky: got %b expected 1", overflow); end
      n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL burst_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL burst_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_full_pop;
      int t;
      bit ok;
      do_reset;
      data = 12'h101;
      dv   = 1'b1;
      push_sample(12'h101);
      @(negedge clk);
      dv = 1'b0;
      t  = 0;
      while (tx !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL fullpop_start: tx got %b expected 0", tx); end
      // First frame started on the clock edge just before this point
      for (int i = 2; i <= 5; i++) begin
         pulse(12'(256 + i));
         push_sample(12'(256 + i));
      end
      n_vec++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL fullpop_full: got %0d expected %0d", fifo_level, DEPTH); end
      repeat (20 * CPB - 8) @(negedge clk);
      // Frame has ended; the pop is on the coming edge, together with this event
      data = 12'h1F5;
      dv   = 1'b1;
      push_sample(12'h1F5);
      @(negedge clk);
      dv = 1'b0;
      n_vec++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL fullpop_level: got %0d expected %0d", fifo_level, DEPTH); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
      drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL fullpop_drain: busy stuck, got %b expected 0", busy); end
      n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL fullpop_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fullpop_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid;
      bit ok;
      do_reset;
      pulse(12'h123);
      pulse(12'h456);
      repeat (25) @(negedge clk);
      n_vec++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL midrst_pre_level: got %0d expected 1", fifo_level); end
      rst_n = 1'b0;
      dv    = 1'b1;
      #1;
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b expected 1", tx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
      rx_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // dv stays high across release: not a sample
      repeat (50) @(negedge clk);
      n_vec++; if (busy !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL midrst_no_event: busy=%b level=%0d expected 0/0", busy, fifo_level); end
      n_vec++; if (rx_q.size() != 0) begin n_err++; $display("FAIL midrst_no_resume: got %0d bytes expected 0", rx_q.size()); end
      dv = 1'b0;
      repeat (2) @(negedge clk);
      pulse(12'h789);
      push_sample(12'h789);
      drain(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_drain: busy stuck, got %b expected 0", busy); end
      n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL midrst_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
      end
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_random;
      bit ok;
      logic [11:0] d;
      int nb;
      do_reset;
      for (int b = 0; b < 6; b++) begin
         // At most one in flight plus four buffered, so nothing is dropped
         nb = int'($urandom_range(5, 1));
         for (int k = 0; k < nb; k++) begin
            d = 12'($urandom);
            pulse(d);
            push_sample(d);
            repeat ($urandom_range(18, 0)) @(negedge clk);
         end
         drain(ok);
         n_vec++; if (!ok) begin n_err++; $display("FAIL random_drain%0d: busy stuck, got %b expected 0", b, busy); end
         n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count%0d: got %0d expected %0d", b, rx_q.size(), exp_q.size()); end
         foreach (exp_q[i]) if (i < rx_q.size()) begin
            n_vec++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_b%0d_byte%0d: got %02h expected %02h", b, i, rx_q[i], exp_q[i]); end
         end
         rx_q.delete(); exp_q.delete();
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL random_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_framing;
      n_vec++; if (mon_err != 0) begin n_err++; $display("FAIL framing_errors: got %0d expected 0", mon_err); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_boundary;
      test_level_dv;
      test_burst;
      test_full_pop;
      test_reset_mid;
      test_random;
      test_framing;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ecg_sample_uart_tx.md
ECG_SAMPLE_UART_TX -- requirements
Module: ecg_sample_uart_tx

Interface
REQ-001 SHALL have parameter FCLK, default 100e6, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = FCLK/BAUD rounded to nearest integer (868 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, sample buffer depth; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data  input  12  ADC sample word from the upstream SPI master, stable whenever dv is high.
REQ-007 SHALL have port dv  input  1  upstream data-valid level; each low-to-high transition marks one new sample.
REQ-008 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port busy  output  1  high while the FIFO is non-empty or a frame is in transmission.
REQ-010 SHALL have port overflow  output  1  sticky flag, set when a sample is dropped.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  number of samples currently buffered.

Function
REQ-012 SHALL register dv into dv_q each cycle; a sample event is dv=1 and dv_q=0 in the same cycle.
REQ-013 SHALL write data into the FIFO on the clock edge of a sample event; level-high dv without a transition SHALL never cause a write.
REQ-014 SHALL accept a write when fifo_level < FIFO_DEPTH, or when fifo_level = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL otherwise discard the sample, leave FIFO contents unchanged and set overflow.
REQ-016 SHALL update fifo_level by +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-017 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-018 SHALL encode each sample D as two bytes sent back to back: byte0 = {1,0,D[11:6]}, byte1 = {0,0,D[5:0]}; bit 7 is the frame sync.
REQ-019 SHALL implement a transmit FSM with states IDLE, START, DATA, STOP and a byte-index bit.
REQ-020 In IDLE with fifo_level > 0, the FSM SHALL pop one sample, latch it, load byte0, clear the byte index and go to START.
REQ-021 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-022 DATA SHALL drive bits 0..7 of the current byte, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-023 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-024 At the end of STOP with byte index 0, the FSM SHALL load byte1, set the byte index and go to START.
REQ-025 At the end of STOP with byte index 1, the FSM SHALL go to IDLE; the next frame MAY start on the following cycle.
REQ-026 SHALL register tx; tx SHALL be 1 in IDLE.
REQ-027 Frame length SHALL be exactly 20*CLKS_PER_BIT cycles of tx activity per sample.
REQ-028 With the FSM in IDLE and the FIFO empty, tx SHALL go low no later than 3 clk cycles after the cycle containing the sample event.
REQ-029 SHALL drive busy = (state != IDLE) or (fifo_level != 0), registered or combinational from registers.
REQ-030 The bit-period counter SHALL wrap from CLKS_PER_BIT-1 to 0 and run only outside IDLE.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force: state=IDLE, tx=1, busy=0, overflow=0, fifo_level=0, pointers=0, dv_q=0, and the bit counter and byte index to 0.
REQ-032 SHALL, on reset mid-frame, abort the frame immediately (tx=1) and discard all buffered samples; FIFO RAM contents need not be cleared.
REQ-033 SHALL treat dv already high at reset release as no event until dv has been seen low and then high.

Verification (FCLK=1e6, BAUD=100000, CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-034 Single sample: data=0xABC with one dv rising edge -> tx carries 0xAA then 0x3C, LSB first with start/stop bits; 200 tx cycles; busy then returns 0.
REQ-035 Level dv: dv held high 1000 cycles with one rising edge -> exactly one frame is sent.
REQ-036 Burst: 6 events 2 cycles apart, samples 0x001..0x006 -> frames for 0x001 to 0x005 are sent in order; 0x006 is dropped (1 in flight, 4 buffered); overflow=1 and stays set.
REQ-037 Full with simultaneous pop: FIFO full and an event on the same cycle the FSM pops -> sample accepted, overflow stays 0, fifo_level stays 4.
REQ-038 Reset mid-frame: rst_n low during DATA of byte0 -> tx=1, busy=0, fifo_level=0 within the same cycle; no frame resumes after release.
REQ-039 Boundary values: samples 0x000 and 0xFFF -> byte pairs 0x80,0x00 and 0xBF,0x3F.
